hazard_flush_ctrl: RTL and testbench

//  Pipeline control unit sequencing the IF/ID stage register and the PC of the 5-stage core.

---
 rtl/hazard_flush_ctrl_if.sv | 37 +++
 rtl/hazard_flush_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-side bundle for the hazard/flush controller.
// The master side is the pipeline datapath (it drives the hazard inputs).
// The slave side is the controller (it drives the stage-register controls).
interface hazard_flush_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rt_i;
  logic             id_jump_i;
  logic             id_ex_mem_read_i;
  logic [REG_W-1:0] id_ex_rt_i;
  logic             ex_branch_taken_i;
  logic             imem_ready_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             imem_err_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_jump_i,
    output id_ex_mem_read_i, id_ex_rt_i, ex_branch_taken_i, imem_ready_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    input  stall_cnt_o, flush_cnt_o, imem_err_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_jump_i,
    input  id_ex_mem_read_i, id_ex_rt_i, ex_branch_taken_i, imem_ready_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    output stall_cnt_o, flush_cnt_o, imem_err_o
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Hazard / flush controller for the 5-stage core.
// Gates the PC and IF/ID / ID/EX registers on load-use hazards, control
// redirects and instruction-memory waits. Control outputs are combinational
// from state and inputs; state, event counters and the timeout flag are flops.
module hazard_flush_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 64
) (
  input logic              clk,
  input logic              reset,
  hazard_flush_ctrl_if.slave bus
);

  // Flush counter only has to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WT_W = $clog2(TIMEOUT + 1);

  localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WT_W-1:0]  WT_LIMIT  = WT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Saturating increment: event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             imem_err_q, imem_err_d;

  logic branch;
  logic load_use;
  logic pc_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic stall_ev;
  logic flush_ev;

  assign branch = bus.ex_branch_taken_i;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.id_ex_mem_read_i
                 && (bus.id_ex_rt_i != REG_W'(0))
                 && ((bus.id_ex_rt_i == bus.id_rs_i)
                     || (bus.id_uses_rt_i && (bus.id_ex_rt_i == bus.id_rt_i)));

  // State register and all counters; synchronous active-low reset abandons any flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      imem_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      imem_err_q  <= imem_err_d;
    end
  end

  // Next-state: a taken branch opens (or restarts) the multi-cycle flush window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (branch && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_RELOAD;
        end else begin
          state_d = ST_RUN;
          fcnt_d  = fcnt_q;
        end
      end
      ST_FLUSH: begin
        if (branch) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_RELOAD;
        end else if (fcnt_q <= FC_W'(1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end else begin
          state_d = ST_FLUSH;
          fcnt_d  = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Output decode: reset forces a safe hold; RUN applies the redirect/hazard priority.
  always_comb begin
    pc_write     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_ev     = 1'b1;
          end else if (bus.id_jump_i) begin
            if_id_flush  = 1'b1;
            flush_ev     = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_ev     = 1'b1;
          end else if (!bus.imem_ready_i) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
          end else begin
            pc_write     = 1'b1;
          end
        end
        ST_FLUSH: begin
          // ID holds a flushed NOP here, so only a new branch matters.
          if_id_flush = 1'b1;
          if (branch) begin
            id_ex_bubble = 1'b1;
            flush_ev     = 1'b1;
          end else begin
            id_ex_bubble = 1'b0;
          end
        end
        default: begin
          pc_write     = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Counter updates: saturating event counters and the imem wait watchdog.
  always_comb begin
    stall_cnt_d = stall_ev ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_ev ? sat_inc(flush_cnt_q) : flush_cnt_q;
    if (!bus.imem_ready_i) begin
      wait_cnt_d = (wait_cnt_q >= WT_LIMIT) ? WT_LIMIT : wait_cnt_q + WT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
    imem_err_d = imem_err_q | (wait_cnt_d >= WT_LIMIT);
  end

  // IF/ID never loads while the PC is held, so its write enable tracks pc_write.
  assign bus.pc_write_o     = pc_write;
  assign bus.if_id_write_o  = pc_write;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_bubble_o = id_ex_bubble;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.flush_cnt_o    = flush_cnt_q;
  assign bus.imem_err_o     = imem_err_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl. Two instances share the stimulus:
// A (FLUSH_CYCLES=3, CNT_W=4, TIMEOUT=8) and B (defaults 1/16/64).
// A cycle-level reference model predicts each cycle's outputs; a monitor
// on the falling edge pops and compares.
module tb_hazard_flush_ctrl;

  logic clk;
  logic reset;

  hazard_flush_ctrl_if #(.REG_W(5), .CNT_W(4))  bus_a ();
  hazard_flush_ctrl_if #(.REG_W(5), .CNT_W(16)) bus_b ();

  hazard_flush_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  hazard_flush_ctrl #(.REG_W(5), .FLUSH_CYCLES(1), .CNT_W(16), .TIMEOUT(64)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic pc;
    logic wr;
    logic fl;
    logic bub;
    logic err;
    int   stall;
    int   flush;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Reference model parameters and state (index 0 = A, 1 = B).
  int p_fc[2]  = '{3, 1};
  int p_to[2]  = '{8, 64};
  int p_max[2] = '{15, 65535};
  int m_rem[2];     // flush cycles still owed after the current one
  int m_stall[2];
  int m_flush[2];
  int m_wait[2];
  logic m_err[2];

  // Current stimulus.
  logic       s_rst, s_ut, s_j, s_mr, s_br, s_rdy;
  logic [4:0] s_rs, s_rt, s_exrt;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_idle();
    s_rst = 1'b1; s_rs = 5'd1; s_rt = 5'd2; s_ut = 1'b0; s_j = 1'b0;
    s_mr = 1'b0; s_exrt = 5'd3; s_br = 1'b0; s_rdy = 1'b1;
  endtask

  task automatic drive();
    reset = s_rst;
    bus_a.id_rs_i = s_rs; bus_a.id_rt_i = s_rt; bus_a.id_uses_rt_i = s_ut;
    bus_a.id_jump_i = s_j; bus_a.id_ex_mem_read_i = s_mr; bus_a.id_ex_rt_i = s_exrt;
    bus_a.ex_branch_taken_i = s_br; bus_a.imem_ready_i = s_rdy;
    bus_b.id_rs_i = s_rs; bus_b.id_rt_i = s_rt; bus_b.id_uses_rt_i = s_ut;
    bus_b.id_jump_i = s_j; bus_b.id_ex_mem_read_i = s_mr; bus_b.id_ex_rt_i = s_exrt;
    bus_b.ex_branch_taken_i = s_br; bus_b.imem_ready_i = s_rdy;
  endtask

  // Predict this cycle's outputs for instance k, then advance the model past the edge.
  task automatic model_cycle(input int k, output exp_t e);
    logic hazard;
    logic pc, fl, bub;
    int   ns, nf, nrem;
    e.stall = m_stall[k];
    e.flush = m_flush[k];
    e.err   = m_err[k];
    if (!s_rst) begin
      e.pc = 1'b0; e.wr = 1'b0; e.fl = 1'b1; e.bub = 1'b1;
      m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0; m_err[k] = 1'b0;
    end else begin
      hazard = s_mr && (s_exrt != 5'd0) &&
               ((s_exrt == s_rs) || (s_ut && (s_exrt == s_rt)));
      pc = 1'b1; fl = 1'b0; bub = 1'b0;
      ns = m_stall[k]; nf = m_flush[k]; nrem = 0;
      if (m_rem[k] > 0) begin
        fl = 1'b1;
        if (s_br) begin bub = 1'b1; nf = nf + 1; nrem = p_fc[k] - 1; end
        else nrem = m_rem[k] - 1;
      end else if (s_br) begin
        fl = 1'b1; bub = 1'b1; nf = nf + 1; nrem = p_fc[k] - 1;
      end else if (s_j) begin
        fl = 1'b1; nf = nf + 1;
      end else if (hazard) begin
        pc = 1'b0; bub = 1'b1; ns = ns + 1;
      end else if (!s_rdy) begin
        pc = 1'b0; fl = 1'b1;
      end
      e.pc = pc; e.wr = pc; e.fl = fl; e.bub = bub;
      m_rem[k]   = nrem;
      m_stall[k] = imin(ns, p_max[k]);
      m_flush[k] = imin(nf, p_max[k]);
      m_wait[k]  = s_rdy ? 0 : imin(m_wait[k] + 1, p_to[k]);
      if (m_wait[k] >= p_to[k]) m_err[k] = 1'b1;
    end
  endtask

  // Apply one cycle of stimulus: drive, queue expectations, advance to just after the edge.
  task automatic step();
    exp_t e;
    drive();
    model_cycle(0, e); q_a.push_back(e);
    model_cycle(1, e); q_b.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic exp_t sample(input int k);
    exp_t a;
    if (k == 0) begin
      a.pc = bus_a.pc_write_o; a.wr = bus_a.if_id_write_o; a.fl = bus_a.if_id_flush_o;
      a.bub = bus_a.id_ex_bubble_o; a.err = bus_a.imem_err_o;
      a.stall = int'(bus_a.stall_cnt_o); a.flush = int'(bus_a.flush_cnt_o);
    end else begin
      a.pc = bus_b.pc_write_o; a.wr = bus_b.if_id_write_o; a.fl = bus_b.if_id_flush_o;
      a.bub = bus_b.id_ex_bubble_o; a.err = bus_b.imem_err_o;
      a.stall = int'(bus_b.stall_cnt_o); a.flush = int'(bus_b.flush_cnt_o);
    end
    return a;
  endfunction

  task automatic check(input int k, input exp_t e);
    exp_t a;
    a = sample(k);
    tests++;
    if (a.pc !== e.pc || a.wr !== e.wr || a.fl !== e.fl || a.bub !== e.bub ||
        a.err !== e.err || a.stall != e.stall || a.flush != e.flush) begin
      fails++;
      $display("FAIL dut_%s cycle %0d outputs: got pc=%0b wr=%0b fl=%0b bub=%0b stall=%0d flush=%0d err=%0b, expected pc=%0b wr=%0b fl=%0b bub=%0b stall=%0d flush=%0d err=%0b",
               (k == 0) ? "a" : "b", cycle, a.pc, a.wr, a.fl, a.bub, a.stall, a.flush, a.err,
               e.pc, e.wr, e.fl, e.bub, e.stall, e.flush, e.err);
    end
  endtask

  // Monitor: every falling edge the DUTs present a cycle's worth of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin e = q_a.pop_front(); check(0, e); end
      if (q_b.size() > 0) begin e = q_b.pop_front(); check(1, e); end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0; m_err[k] = 1'b0;
    end
    // Warm-up reset edge with no expectations (flop contents unknown before it).
    set_idle(); s_rst = 1'b0; drive();
    @(posedge clk); #1;

    // Reset held for two cycles: forced outputs, zero counters.
    s_rst = 1'b0; step(); step();
    set_idle(); step(); step();

    // Load-use on rs, then normal.
    s_mr = 1'b1; s_exrt = 5'd5; s_rs = 5'd5; step();
    set_idle(); step();
    // r0 load and rt without uses_rt: no stall; rt with uses_rt: stall.
    s_mr = 1'b1; s_exrt = 5'd0; s_rs = 5'd0; step();
    set_idle(); s_mr = 1'b1; s_exrt = 5'd7; s_rt = 5'd7; s_ut = 1'b0; step();
    s_ut = 1'b1; step();
    set_idle(); step();
    // Jump alone, then branch with full flush window.
    s_j = 1'b1; step();
    set_idle(); s_br = 1'b1; step();
    set_idle(); repeat (4) step();
    // Branch + jump + load-use together: branch response only.
    s_br = 1'b1; s_j = 1'b1; s_mr = 1'b1; s_exrt = 5'd5; s_rs = 5'd5; step();
    set_idle(); repeat (4) step();
    // Re-branch inside the flush window, and load-use/jump ignored while flushing.
    s_br = 1'b1; step();
    set_idle(); step();
    s_br = 1'b1; step();
    set_idle(); s_mr = 1'b1; s_exrt = 5'd5; s_rs = 5'd5; s_j = 1'b1; step();
    set_idle(); repeat (4) step();
    // Long imem wait: crosses both timeouts; flag stays set afterwards.
    s_rdy = 1'b0; repeat (70) step();
    set_idle(); repeat (3) step();
    // Reset in the middle of a flush window.
    s_br = 1'b1; step();
    set_idle(); s_rst = 1'b0; step();
    set_idle(); repeat (3) step();
    // Twenty back-to-back stalls: A saturates at 15.
    s_mr = 1'b1; s_exrt = 5'd9; s_rs = 5'd9; repeat (20) step();
    set_idle(); step();

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 199) != 0);
      s_rs   = 5'($urandom_range(0, 3));
      s_rt   = 5'($urandom_range(0, 3));
      s_exrt = 5'($urandom_range(0, 3));
      s_ut   = 1'($urandom_range(0, 1));
      s_mr   = ($urandom_range(0, 2) == 0);
      s_j    = ($urandom_range(0, 7) == 0);
      s_br   = ($urandom_range(0, 7) == 0);
      s_rdy  = ($urandom_range(0, 9) != 0);
      step();
    end
    set_idle(); step();

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 8; w++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
